// File: rtl/game_input_pkg.sv
// Shared definitions for the board-input conditioning path: debounce state
// encoding and debounce length constants.
package game_input_pkg;

    // 10 ms at a 25 MHz pixel clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

    // Short qualification window used when simulating the block.
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    // Debounce state encoding; bit 0 set means the input is currently seen as high
    // (or qualifying towards high) and bit 1 set means the accepted level is high.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } deb_state_e;

    // True while a new level is being qualified.
    function automatic logic deb_is_wait(input deb_state_e st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

endpackage : game_input_pkg

// File: rtl/game_debounce.sv
// One-bit conditioner: two-flop synchronizer, optional polarity inversion,
// debounce FSM with qualification counter, registered level and edge pulses.
module game_debounce
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT, // must be >= 2
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned          CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 active_c;
    logic                 cnt_done_c;
    deb_state_e           state_q;
    deb_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 level_d;
    logic                 rise_q;
    logic                 rise_d;
    logic                 fall_q;
    logic                 fall_d;

    // Synchronized sample normalized so that 1 always means asserted.
    assign active_c   = sync2_q ^ ACTIVE_LOW;
    assign cnt_done_c = (cnt_q == CNT_LAST);

    // State, counter, synchronizer and output registers; synchronizer resets to the idle level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state: any disagreement during qualification falls back to the stable state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STABLE_LO: if (active_c)        state_d = WAIT_HI;
            WAIT_HI: begin
                if (!active_c)              state_d = STABLE_LO;
                else if (cnt_done_c)        state_d = STABLE_HI;
            end
            STABLE_HI: if (!active_c)       state_d = WAIT_LO;
            WAIT_LO: begin
                if (active_c)               state_d = STABLE_HI;
                else if (cnt_done_c)        state_d = STABLE_LO;
            end
        endcase
    end

    // Counter and output next values: counter clears on every state change, level and
    // pulses change only when a qualification completes.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (deb_is_wait(state_q) && !cnt_done_c) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if ((state_q == WAIT_HI) && (state_d == STABLE_HI)) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
        end
        if ((state_q == WAIT_LO) && (state_d == STABLE_LO)) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : game_debounce

// File: rtl/game_input_conditioner.sv
// Board input conditioner: debounces the fire key and the slide switches and
// produces clean levels plus single-cycle press/release/change pulses.
module game_input_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT, // must be >= 2
    parameter int unsigned SW_WIDTH        = 2,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                key_down,
    output logic                key_press,
    output logic                key_release,
    output logic [SW_WIDTH-1:0] sw,
    output logic                sw_changed
);

    logic [SW_WIDTH-1:0] sw_rise;
    logic [SW_WIDTH-1:0] sw_fall;

    // Fire key channel, normalized so key_down = 1 means pressed.
    game_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (KEY_ACTIVE_LOW)
    ) u_key (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (key_raw),
        .level_o (key_down),
        .rise_o  (key_press),
        .fall_o  (key_release)
    );

    // One independent channel per slide switch.
    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
        game_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (1'b0)
        ) u_sw (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (sw_raw[i]),
            .level_o (sw[i]),
            .rise_o  (sw_rise[i]),
            .fall_o  (sw_fall[i])
        );
    end

    // Per-bit pulses are registered and aligned with sw, so one OR gives a single
    // pulse even when several bits settle on the same edge.
    assign sw_changed = |(sw_rise | sw_fall);

endmodule : game_input_conditioner

// File: tb/tb_game_input_conditioner.sv
// Directed bench for game_input_conditioner with a 4-cycle debounce window.
module tb_game_input_conditioner;
    import game_input_pkg::*;

    localparam int unsigned SW_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            key_raw;
    logic [SW_W-1:0] sw_raw;
    logic            key_down;
    logic            key_press;
    logic            key_release;
    logic [SW_W-1:0] sw;
    logic            sw_changed;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          e       = 0;

    logic            exp_down;
    logic            exp_press;
    logic            exp_rel;
    logic [SW_W-1:0] exp_sw;
    logic            exp_chg;

    game_input_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .SW_WIDTH        (SW_W),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .sw_raw      (sw_raw),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .sw          (sw),
        .sw_changed  (sw_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s after edge %0d: observed %b expected %b", tag, e, got, want);
        end
    endtask

    // Advance to edge 'upto', checking every output 1 time unit after each edge.
    task automatic adv(input int upto);
        while (e < upto) begin
            @(posedge clk);
            e++;
            #1;
            chk("key_down",    2'(key_down),    2'(exp_down));
            chk("key_press",   2'(key_press),   2'(exp_press));
            chk("key_release", 2'(key_release), 2'(exp_rel));
            chk("sw",          sw,              exp_sw);
            chk("sw_changed",  2'(sw_changed),  2'(exp_chg));
        end
    endtask

    // Reset held for edges 1..3 with released inputs; restarts the edge count.
    task automatic reset_seq();
        reset     = 1'b0;
        key_raw   = 1'b1;
        sw_raw    = 2'b00;
        exp_down  = 1'b0;
        exp_press = 1'b0;
        exp_rel   = 1'b0;
        exp_sw    = 2'b00;
        exp_chg   = 1'b0;
        e         = 0;
        adv(3);
        reset = 1'b1;
    endtask

    initial begin
        // Reset and clean press: sampled at edge 10, level after edge 16.
        reset_seq();
        adv(9);
        key_raw = 1'b0;
        adv(15);
        exp_down = 1'b1; exp_press = 1'b1;
        adv(16);
        exp_press = 1'b0;
        adv(24);

        // Bounce: low 16..18, high 19, low from 20 -> level after edge 26.
        reset_seq();
        adv(15);
        key_raw = 1'b0;
        adv(18);
        key_raw = 1'b1;
        adv(19);
        key_raw = 1'b0;
        adv(25);
        exp_down = 1'b1; exp_press = 1'b1;
        adv(26);
        exp_press = 1'b0;
        adv(29);

        // Release glitch of 2 edges is filtered; steady release from edge 40.
        key_raw = 1'b1;
        adv(31);
        key_raw = 1'b0;
        adv(39);
        key_raw = 1'b1;
        adv(45);
        exp_down = 1'b0; exp_rel = 1'b1;
        adv(46);
        exp_rel = 1'b0;
        adv(49);

        // Switches: 00->11 at edge 50, then bit 0 low at edge 70.
        sw_raw = 2'b11;
        adv(55);
        exp_sw = 2'b11; exp_chg = 1'b1;
        adv(56);
        exp_chg = 1'b0;
        adv(69);
        sw_raw = 2'b10;
        adv(75);
        exp_sw = 2'b10; exp_chg = 1'b1;
        adv(76);
        exp_chg = 1'b0;
        adv(80);

        // Simultaneous key press and switch change reported on the same cycle.
        key_raw = 1'b0;
        sw_raw  = 2'b01;
        adv(86);
        exp_down = 1'b1; exp_press = 1'b1; exp_sw = 2'b01; exp_chg = 1'b1;
        adv(87);
        exp_press = 1'b0; exp_chg = 1'b0;
        adv(92);

        // Reset mid-qualification at edge 14; press re-qualified, level after edge 21.
        reset_seq();
        adv(9);
        key_raw = 1'b0;
        adv(13);
        reset = 1'b0;
        adv(14);
        reset = 1'b1;
        adv(20);
        exp_down = 1'b1; exp_press = 1'b1;
        adv(21);
        exp_press = 1'b0;
        adv(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_game_input_conditioner
